demux_1to2_complex_seq: RTL and testbench



---
 rtl/fft_pkg.sv | 19 +
 rtl/demux_half_counter.sv | 45 ++++
 rtl/demux_1to2_complex_seq.sv | 136 +++++++++++++
 tb/tb_demux_1to2_complex_seq.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared definitions for the FFT mux/demux/commutator family: sample width and
// routing state encoding.
package fft_pkg;

  localparam int unsigned WL_DEF   = 18;
  localparam int unsigned SAMPLE_W = WL_DEF + 1;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StRoute0 = 2'd1,
    StRoute1 = 2'd2
  } route_state_e;

  // Counter width for a modulo-half counter; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned half);
    return (half > 1) ? $clog2(half) : 1;
  endfunction

endpackage

// File: rtl/demux_half_counter.sv
// Modulo-HALF sample counter with enable, start-of-frame clear-to-one and a
// wrap pulse on the last sample of each half-frame.
module demux_half_counter
  import fft_pkg::*;
#(
  parameter int unsigned HALF = 8,
  localparam int unsigned CW  = cnt_width(HALF)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          clr,
  output logic [CW-1:0] cnt,
  output logic          wrap
);

  localparam logic [CW-1:0] Last = CW'(HALF - 1);
  // The start-of-frame sample itself is the first of the half.
  localparam logic [CW-1:0] SofNext = (HALF > 1) ? CW'(1) : '0;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          at_last;

  assign at_last = (cnt_q == Last);
  assign wrap    = en & ~clr & at_last;
  assign cnt     = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = SofNext;
    end else if (en) begin
      cnt_d = at_last ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/demux_1to2_complex_seq.sv
// Self-sequenced 1-to-2 complex demux: first half-frame to lane 0, second to lane 1.
// Optional macro DEMUX_SYNC_ERR_EN adds a sync_err pulse for early/late frames.
module demux_1to2_complex_seq
  import fft_pkg::*;
#(
  parameter int unsigned WL   = WL_DEF,
  parameter int unsigned HALF = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic               in_sof,
  input  logic signed [WL:0] in_real,
  input  logic signed [WL:0] in_imag,
  output logic signed [WL:0] out0_real,
  output logic signed [WL:0] out0_imag,
  output logic               out0_valid,
  output logic signed [WL:0] out1_real,
  output logic signed [WL:0] out1_imag,
  output logic               out1_valid,
  output logic               sel,
`ifdef DEMUX_SYNC_ERR_EN
  output logic               busy,
  output logic               sync_err
`else
  output logic               busy
`endif
);

  localparam int unsigned CW = cnt_width(HALF);
  // With a one-sample half, the start-of-frame sample already completes lane 0.
  localparam route_state_e SofState = (HALF == 1) ? StRoute1 : StRoute0;

  route_state_e state_q, state_d;

  logic [CW-1:0] cnt;
  logic          wrap;
  logic          cnt_en;
  logic          sof_acc;
  logic          to_lane0;
  logic          to_lane1;

  logic signed [WL:0] out0_re_q, out0_im_q, out1_re_q, out1_im_q;
  logic               out0_vld_q, out1_vld_q;

  assign sof_acc = in_valid & in_sof;
  assign cnt_en  = in_valid & ((state_q != StIdle) | in_sof);

  demux_half_counter #(
    .HALF (HALF)
  ) u_half_counter (
    .clk  (clk),
    .rst  (rst),
    .en   (cnt_en),
    .clr  (sof_acc),
    .cnt  (cnt),
    .wrap (wrap)
  );

  always_comb begin
    state_d  = state_q;
    to_lane0 = 1'b0;
    to_lane1 = 1'b0;
    if (in_valid) begin
      if (in_sof) begin
        // Resync wins over the wrap toggle.
        to_lane0 = 1'b1;
        state_d  = SofState;
      end else begin
        unique case (state_q)
          StRoute0: begin
            to_lane0 = 1'b1;
            if (wrap) state_d = StRoute1;
          end
          StRoute1: begin
            to_lane1 = 1'b1;
            if (wrap) state_d = StRoute0;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      out0_re_q  <= '0;
      out0_im_q  <= '0;
      out1_re_q  <= '0;
      out1_im_q  <= '0;
      out0_vld_q <= 1'b0;
      out1_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      out0_vld_q <= to_lane0;
      out1_vld_q <= to_lane1;
      if (to_lane0) begin
        out0_re_q <= in_real;
        out0_im_q <= in_imag;
      end
      if (to_lane1) begin
        out1_re_q <= in_real;
        out1_im_q <= in_imag;
      end
    end
  end

  assign out0_real  = out0_re_q;
  assign out0_imag  = out0_im_q;
  assign out0_valid = out0_vld_q;
  assign out1_real  = out1_re_q;
  assign out1_imag  = out1_im_q;
  assign out1_valid = out1_vld_q;
  assign sel        = (state_q == StRoute1);
  assign busy       = (state_q != StIdle);

`ifdef DEMUX_SYNC_ERR_EN
  logic sync_err_q;

  // A frame start is only expected on the first sample of lane 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_err_q <= 1'b0;
    end else begin
      sync_err_q <= sof_acc & (((state_q == StRoute0) & (cnt != '0)) | (state_q == StRoute1));
    end
  end

  assign sync_err = sync_err_q;
`else
  logic unused_cnt;
  assign unused_cnt = ^cnt;
`endif

endmodule

// File: tb/tb_demux_1to2_complex_seq.sv
// Table-driven, scoreboard-checked bench for demux_1to2_complex_seq (HALF=4).
module tb_demux_1to2_complex_seq;

  localparam int unsigned WL   = 18;
  localparam int unsigned HALF = 4;
  localparam int unsigned W    = WL + 1;
  localparam logic [1:0]  NONE = 2'd2;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_sof;
  logic [W-1:0] in_real, in_imag;
  logic [W-1:0] out0_real, out0_imag, out1_real, out1_imag;
  logic         out0_valid, out1_valid, sel, busy;
`ifdef DEMUX_SYNC_ERR_EN
  logic         sync_err;
`endif

  always #5 clk = ~clk;

  demux_1to2_complex_seq #(
    .WL   (WL),
    .HALF (HALF)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_sof     (in_sof),
    .in_real    (in_real),
    .in_imag    (in_imag),
    .out0_real  (out0_real),
    .out0_imag  (out0_imag),
    .out0_valid (out0_valid),
    .out1_real  (out1_real),
    .out1_imag  (out1_imag),
    .out1_valid (out1_valid),
    .sel        (sel),
`ifdef DEMUX_SYNC_ERR_EN
    .busy       (busy),
    .sync_err   (sync_err)
`else
    .busy       (busy)
`endif
  );

  typedef struct {
    logic         v;
    logic         sof;
    logic [W-1:0] re;
    logic [W-1:0] im;
    logic [1:0]   lane;
    logic         err;
    logic         sel;
    logic         busy;
  } vec_t;

  typedef struct {
    logic [1:0]   lane;
    logic [W-1:0] re;
    logic [W-1:0] im;
    logic         err;
  } exp_t;

  vec_t tbl[$];
  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  logic [W-1:0] last0_re = '0, last0_im = '0, last1_re = '0, last1_im = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic vec_t mk(input logic v, input logic sof, input logic [W-1:0] re,
                              input logic [W-1:0] im, input logic [1:0] lane,
                              input logic err, input logic s, input logic b);
    vec_t t;
    t.v = v; t.sof = sof; t.re = re; t.im = im;
    t.lane = lane; t.err = err; t.sel = s; t.busy = b;
    return t;
  endfunction

  task automatic apply(input vec_t t, input string tag);
    exp_t e;
    logic got;
    @(negedge clk);
    in_valid = t.v;
    in_sof   = t.sof;
    in_real  = t.re;
    in_imag  = t.im;
    if (t.v && t.lane != NONE) exp_q.push_back('{t.lane, t.re, t.im, t.err});
    @(posedge clk);
    #1;
    got = 1'b0;
    e   = '{NONE, '0, '0, 1'b0};
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      got = 1'b1;
    end
    if (got && e.lane == 2'd0) begin last0_re = e.re; last0_im = e.im; end
    if (got && e.lane == 2'd1) begin last1_re = e.re; last1_im = e.im; end
    chk({tag, " out0_valid"}, out0_valid, got && e.lane == 2'd0);
    chk({tag, " out1_valid"}, out1_valid, got && e.lane == 2'd1);
    chk({tag, " out0_real"}, out0_real, last0_re);
    chk({tag, " out0_imag"}, out0_imag, last0_im);
    chk({tag, " out1_real"}, out1_real, last1_re);
    chk({tag, " out1_imag"}, out1_imag, last1_im);
    chk({tag, " sel"}, sel, t.sel);
    chk({tag, " busy"}, busy, t.busy);
`ifdef DEMUX_SYNC_ERR_EN
    chk({tag, " sync_err"}, sync_err, got && e.err);
`endif
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " out0_real"}, out0_real, '0);
    chk({tag, " out0_imag"}, out0_imag, '0);
    chk({tag, " out1_real"}, out1_real, '0);
    chk({tag, " out1_imag"}, out1_imag, '0);
    chk({tag, " out0_valid"}, out0_valid, 1'b0);
    chk({tag, " out1_valid"}, out1_valid, 1'b0);
    chk({tag, " sel"}, sel, 1'b0);
    chk({tag, " busy"}, busy, 1'b0);
`ifdef DEMUX_SYNC_ERR_EN
    chk({tag, " sync_err"}, sync_err, 1'b0);
`endif
  endtask

  initial begin
    logic [1:0]   rs_lane [13];
    logic         rs_sel  [13];
    logic [W-1:0] ex_re   [8];
    logic [W-1:0] ex_im   [8];
    logic [W-1:0] pos_max, neg_min;

    rst      = 1'b1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    in_real  = '0;
    in_imag  = '0;

    // Idle drops, nominal frame, bubbled frame, continuous wrap.
    for (int k = 0; k < 2; k++)
      tbl.push_back(mk(1'b1, 1'b0, W'(100 + k), W'(200 + k), NONE, 1'b0, 1'b0, 1'b0));
    for (int i = 1; i <= 8; i++)
      tbl.push_back(mk(1'b1, i == 1, W'(i), W'(-i), 2'(((i - 1) / 4) % 2), 1'b0,
                       ((i / 4) % 2) == 1, 1'b1));
    for (int i = 1; i <= 8; i++) begin
      tbl.push_back(mk(1'b1, i == 1, W'(i), W'(-i), 2'(((i - 1) / 4) % 2), 1'b0,
                       ((i / 4) % 2) == 1, 1'b1));
      tbl.push_back(mk(1'b0, 1'b0, W'(77), W'(88), NONE, 1'b0, ((i / 4) % 2) == 1, 1'b1));
    end
    for (int i = 1; i <= 12; i++)
      tbl.push_back(mk(1'b1, i == 1, W'(i), W'(-i), 2'(((i - 1) / 4) % 2), 1'b0,
                       ((i / 4) % 2) == 1, 1'b1));

    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    foreach (tbl[n]) apply(tbl[n], $sformatf("tbl[%0d]", n));

    // Mid-frame reset: state is ROUTE1 here, so the sof is a late frame.
    apply(mk(1'b1, 1'b1, W'(500), W'(501), 2'd0, 1'b1, 1'b0, 1'b1), "mrst s1");
    apply(mk(1'b1, 1'b0, W'(502), W'(503), 2'd0, 1'b0, 1'b0, 1'b1), "mrst s2");
    @(negedge clk);
    in_valid = 1'b0;
    rst      = 1'b1;
    #1;
    chk_all_zero("async reset");
    exp_q.delete();
    last0_re = '0; last0_im = '0; last1_re = '0; last1_im = '0;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 2; k++)
      apply(mk(1'b1, 1'b0, W'(600 + k), W'(700 + k), NONE, 1'b0, 1'b0, 1'b0), "post rst");

    // Early resync: sof on the 6th sample (ROUTE1, cnt=1).
    rs_lane = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0,
                2'd1, 2'd1, 2'd1, 2'd1};
    rs_sel  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1,
                1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 13; i++)
      apply(mk(1'b1, (i == 0) || (i == 5), W'(i + 31), W'(-(i + 31)), rs_lane[i], i == 5,
               rs_sel[i], 1'b1), $sformatf("resync s%0d", i + 1));

    // Extremes on both lanes.
    pos_max = 19'h3FFFF;
    neg_min = 19'h40000;
    ex_re = '{pos_max, neg_min, pos_max, neg_min, pos_max, neg_min, pos_max, neg_min};
    ex_im = '{neg_min, pos_max, pos_max, neg_min, neg_min, pos_max, pos_max, neg_min};
    for (int i = 0; i < 8; i++)
      apply(mk(1'b1, i == 0, ex_re[i], ex_im[i], 2'(i / 4), 1'b0, (i >= 3) && (i < 7), 1'b1),
            $sformatf("extreme s%0d", i + 1));

    @(negedge clk);
    in_valid = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
